sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock synchronous FIFO with a valid/ready-style write/read interface and first-word-fall-through output. It buffers `WIDTH`-bit words between a producer and a consumer in the same clock domain. It is the generic queueing block used between pipeline stages in the SoC.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 3: number of storage entries, any integer ≥ 2 (need not be a power of two).
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: reset is synchronous and active-low.
- `w_valid`  in  1: write request; `data_in` is captured at the edge when `w_valid && !fifo_full`.
- `r_ready`  in  1: read request; the head word is consumed at the edge when `r_ready && !fifo_empty`.
- `data_in`  in  WIDTH: write data.
- `data_out`  out  WIDTH: current head word (show-ahead).
- `fifo_full`  out  1: high when the occupancy equals `DEPTH`.
- `fifo_empty`  out  1: high when the occupancy is 0.

## Operation
- State:
  - Write pointer and read pointer, each `$clog2(DEPTH)` bits, wrapping from `DEPTH-1` to 0. Wrap is an explicit compare, not a modulo-2^n overflow.
  - Occupancy count, 0..`DEPTH`, held in `$clog2(DEPTH)+1` bits.
- Push (`w_valid && !fifo_full`): write `mem[wr_ptr] <= data_in`, advance `wr_ptr`, increment count.
- Pop (`r_ready && !fifo_empty`): advance `rd_ptr`, decrement count.
- Simultaneous push and pop:
  - Both occur and the count is unchanged.
  - When full, the push is blocked, because `fifo_full` gates the write regardless of `r_ready`.
  - When empty, only the push occurs.
- Overflow: a write attempt while full is silently dropped, with no state change.
- Underflow: a read attempt while empty is ignored.
- `data_out` = `mem[rd_ptr]` when not empty, and all-zero when empty.
- Flags are decoded from the count register: `fifo_full = (count == DEPTH)`, `fifo_empty = (count == 0)`.
- Reset, including mid-operation:
  - Clears the pointers and the count, giving `fifo_empty=1`, `fifo_full=0` and `data_out=0`.
  - Storage contents are not cleared.
  - Reset has priority over push and pop in the same cycle.

## Timing
- Write latency is 1 cycle. A word pushed at edge N appears on `data_out` after edge N if the FIFO was empty, and `fifo_empty` falls after edge N.
- A pop at edge N presents the next word on `data_out` after edge N. The consumer samples `data_out` in the same cycle it asserts `r_ready`.
- `fifo_full` rises after the edge that stores the `DEPTH`-th word. It falls after the first pop from full.
- All outputs are registered state or combinational decode of registered state. There is no combinational path from `w_valid`, `r_ready` or `data_in` to any output.

## Configuration
- `SYNC_FIFO_ERR_EN` defined:
  - Adds output `fifo_err` (1 bit), a sticky flag.
  - It is set at any edge with `w_valid && fifo_full` or `r_ready && fifo_empty`.
  - It is cleared only by reset.
- `SYNC_FIFO_ERR_EN` undefined: the port and its logic are absent, and illegal requests are silently ignored as described above.

## Structure
- Package `sync_fifo_pkg` holds:
  - default constants `SYNC_FIFO_WIDTH_DEF=32` and `SYNC_FIFO_DEPTH_DEF=3`;
  - a function computing pointer width, `max(1,$clog2(DEPTH))`.
- Sub-module `sync_fifo_mem` holds the storage array: 1 synchronous write port and 1 asynchronous read port. The top level holds the pointers, the count, the flags and the output muxing.

## Test plan
All scenarios use `WIDTH=32`, `DEPTH=3`.
- Reset pulse with idle inputs -> `fifo_empty=1`, `fifo_full=0`, `data_out=0`.
- Push 0, 1, 2 on consecutive cycles -> `fifo_full=0` after the 1st and 2nd edges; `fifo_full=1` after the 3rd edge.
- Push 3 while full, then pop three times -> the pops return 0, 1, 2; the value 3 is never seen; `fifo_empty=1` after the last pop; `fifo_err=1` if `SYNC_FIFO_ERR_EN` is defined.
- After the pointers have advanced by 3, push 4 then pop -> `data_out=4` (wrap to index 0); `fifo_empty=1` afterwards.
- With 1 entry (0xA), push 0xB and pop in the same cycle -> count stays 1 and `data_out=0xB` afterwards. With the FIFO full, assert both -> only the pop occurs and the count becomes 2.
- With 2 entries, assert `reset` low for one edge while `w_valid=1` -> `fifo_empty=1`, `data_out=0`, and no write occurs.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and sizing helper for the sync_fifo block.
//   SYNC_FIFO_WIDTH_DEF : default data word width
//   SYNC_FIFO_DEPTH_DEF : default number of storage entries
//   sync_fifo_ptr_w()   : pointer width for a given depth, never below 1 bit
package sync_fifo_pkg;

  localparam int SYNC_FIFO_WIDTH_DEF = 32;
  localparam int SYNC_FIFO_DEPTH_DEF = 3;

  // Pointer width is at least one bit so a depth of 1 or 2 still has a usable index.
  function automatic int sync_fifo_ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: storage array for sync_fifo. One synchronous write port,
// one asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from raddr)
module sync_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port; pointers never exceed DEPTH-1 so no range guard is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-low; clears pointers/count (not storage)
//   w_valid    : write request, accepted when not full
//   r_ready    : read request, head consumed when not empty
//   data_in    : write data
//   data_out   : head word, zero while empty
//   fifo_full  : occupancy == DEPTH
//   fifo_empty : occupancy == 0
//   fifo_err   : sticky illegal-access flag, only when SYNC_FIFO_ERR_EN is defined
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = SYNC_FIFO_WIDTH_DEF,
  parameter int DEPTH = SYNC_FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  input  logic             r_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic             fifo_err
`endif
);

  localparam int PTR_W = sync_fifo_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] rdata_s;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Flags come only from the count register, so no input reaches an output.
  assign fifo_full  = (count_r == CNT_FULL);
  assign fifo_empty = (count_r == {CNT_W{1'b0}});
  assign push_s     = w_valid && !fifo_full;
  assign pop_s      = r_ready && !fifo_empty;

  sync_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s && reset),
    .waddr (wr_ptr_r),
    .wdata (data_in),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Pointer and occupancy update; reset overrides any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Show-ahead output, forced to zero while empty so stale storage is hidden.
  always_comb begin
    data_out = {WIDTH{1'b0}};
    if (fifo_empty) begin
      data_out = {WIDTH{1'b0}};
    end else begin
      data_out = rdata_s;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic err_r;

  // Sticky record of any write-while-full or read-while-empty attempt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if ((w_valid && fifo_full) || (r_ready && fifo_empty)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign fifo_err = err_r;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo at WIDTH=32, DEPTH=3.
module tb_sync_fifo;

  logic        clk;
  logic        reset;
  logic        w_valid;
  logic        r_ready;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        fifo_full;
  logic        fifo_empty;
`ifdef SYNC_FIFO_ERR_EN
  logic        fifo_err;
`endif

  int errors;
  int checks;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w_valid    (w_valid),
    .r_ready    (r_ready),
    .data_in    (data_in),
    .data_out   (data_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .fifo_err   (fifo_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    w_valid = 1'b0;
    r_ready = 1'b0;
    data_in = 32'h0;

    // Reset with idle inputs
    step();
    step();
    reset = 1'b1;
    check("rst_empty", {31'h0, fifo_empty}, 32'h1);
    check("rst_full", {31'h0, fifo_full}, 32'h0);
    check("rst_dout", data_out, 32'h0);
`ifdef SYNC_FIFO_ERR_EN
    check("rst_err", {31'h0, fifo_err}, 32'h0);
`endif

    // Fill with 0,1,2
    w_valid = 1'b1;
    data_in = 32'h0;
    step();
    check("p0_full", {31'h0, fifo_full}, 32'h0);
    check("p0_empty", {31'h0, fifo_empty}, 32'h0);
    check("p0_dout", data_out, 32'h0);
    data_in = 32'h1;
    step();
    check("p1_full", {31'h0, fifo_full}, 32'h0);
    data_in = 32'h2;
    step();
    check("p2_full", {31'h0, fifo_full}, 32'h1);
`ifdef SYNC_FIFO_ERR_EN
    check("p2_err", {31'h0, fifo_err}, 32'h0);
`endif

    // Overflow attempt is dropped
    data_in = 32'h3;
    step();
    w_valid = 1'b0;
    check("ovf_full", {31'h0, fifo_full}, 32'h1);
    check("ovf_dout", data_out, 32'h0);

    // Drain: 0 already at head, then 1, 2, then empty
    r_ready = 1'b1;
    step();
    check("pop0_next", data_out, 32'h1);
    check("pop0_full", {31'h0, fifo_full}, 32'h0);
    step();
    check("pop1_next", data_out, 32'h2);
    step();
    r_ready = 1'b0;
    check("pop2_empty", {31'h0, fifo_empty}, 32'h1);
    check("pop2_dout", data_out, 32'h0);
`ifdef SYNC_FIFO_ERR_EN
    check("ovf_err", {31'h0, fifo_err}, 32'h1);
`endif

    // Pointers wrapped to 0: push 4 then pop
    w_valid = 1'b1;
    data_in = 32'h4;
    step();
    w_valid = 1'b0;
    check("wrap_dout", data_out, 32'h4);
    check("wrap_empty", {31'h0, fifo_empty}, 32'h0);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check("wrap_pop_empty", {31'h0, fifo_empty}, 32'h1);

    // One entry 0xA, simultaneous push 0xB / pop
    w_valid = 1'b1;
    data_in = 32'hA;
    step();
    data_in = 32'hB;
    r_ready = 1'b1;
    step();
    w_valid = 1'b0;
    r_ready = 1'b0;
    check("pp1_dout", data_out, 32'hB);
    check("pp1_empty", {31'h0, fifo_empty}, 32'h0);
    check("pp1_full", {31'h0, fifo_full}, 32'h0);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check("pp1_cnt1", {31'h0, fifo_empty}, 32'h1);

    // Full, simultaneous push/pop: only the pop occurs
    w_valid = 1'b1;
    data_in = 32'h11;
    step();
    data_in = 32'h22;
    step();
    data_in = 32'h33;
    step();
    check("ppf_full_pre", {31'h0, fifo_full}, 32'h1);
    data_in = 32'h44;
    r_ready = 1'b1;
    step();
    w_valid = 1'b0;
    check("ppf_full", {31'h0, fifo_full}, 32'h0);
    check("ppf_dout", data_out, 32'h22);
    step();
    check("ppf_dout2", data_out, 32'h33);
    step();
    r_ready = 1'b0;
    check("ppf_cnt2", {31'h0, fifo_empty}, 32'h1);

    // Two entries, then reset with w_valid high
    w_valid = 1'b1;
    data_in = 32'h55;
    step();
    data_in = 32'h66;
    step();
    check("rs2_dout", data_out, 32'h55);
    reset   = 1'b0;
    data_in = 32'h77;
    step();
    reset   = 1'b1;
    w_valid = 1'b0;
    check("rs2_empty", {31'h0, fifo_empty}, 32'h1);
    check("rs2_full", {31'h0, fifo_full}, 32'h0);
    check("rs2_dout", data_out, 32'h0);
`ifdef SYNC_FIFO_ERR_EN
    check("rs2_err", {31'h0, fifo_err}, 32'h0);
`endif

    // Normal operation resumes from index 0
    w_valid = 1'b1;
    data_in = 32'h88;
    step();
    w_valid = 1'b0;
    check("post_dout", data_out, 32'h88);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check("post_empty", {31'h0, fifo_empty}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
